// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with start/done handshake and per-operation signed mode.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CHECK, S_ADD, S_SHIFT, S_FIX, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_hold_q, a_hold_d;
  logic [WIDTH-1:0]     b_hold_q, b_hold_d;
  logic                 sgn_hold_q, sgn_hold_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // The most-negative operand negates to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  always_comb begin
    mag_a = (sgn_hold_q && a_hold_q[WIDTH-1]) ? (~a_hold_q + WIDTH'(1)) : a_hold_q;
    mag_b = (sgn_hold_q && b_hold_q[WIDTH-1]) ? (~b_hold_q + WIDTH'(1)) : b_hold_q;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    sgn_hold_d = sgn_hold_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    product_d  = product_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_hold_d   = i_multiplicand;
          b_hold_d   = i_multiplier;
          sgn_hold_d = i_signed;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        mcand_d  = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
        acc_d    = '0;
        cnt_d    = '0;
        neg_d    = sgn_hold_q & (a_hold_q[WIDTH-1] ^ b_hold_q[WIDTH-1]);
        state_d  = S_CHECK;
      end
      S_CHECK: begin
`ifdef MULT_EARLY_TERM_EN
        if (mplier_q == '0)   state_d = S_FIX;
        else if (mplier_q[0]) state_d = S_ADD;
        else                  state_d = S_SHIFT;
`else
        if (mplier_q[0]) state_d = S_ADD;
        else             state_d = S_SHIFT;
`endif
      end
      S_ADD: begin
        acc_d   = acc_q + mcand_q;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_CHECK;
        end
      end
      S_FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with the state they describe.
    busy_d = (state_d == S_INIT) || (state_d == S_CHECK) || (state_d == S_ADD) ||
             (state_d == S_SHIFT) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      sgn_hold_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      product_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      sgn_hold_q <= sgn_hold_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      product_q  <= product_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=8; build with MULT_EARLY_TERM_EN to check the early-exit latencies.
module tb_seq_shift_add_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_mis = 0;

  seq_shift_add_mult #(.WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_signed       (sgn),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Picks the hand-computed latency for the build being simulated.
  function automatic int pick(input int fixed_lat, input int early_lat);
`ifdef MULT_EARLY_TERM_EN
    return early_lat;
`else
    return fixed_lat;
`endif
  endfunction

  // Starts one operation and waits (bounded) for o_done; lat counts edges after the start-sampling edge.
  task automatic do_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       output logic [15:0] prod, output int lat,
                       output logic busy_at_done, output logic done_next);
    @(negedge clk);
    start = 1'b1; sgn = s; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    prod         = product;
    busy_at_done = busy;
    @(posedge clk);
    #1 done_next = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)     begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_mis++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (product !== 16'h0) begin n_mis++; $display("FAIL reset_product got %h want 0000", product); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vec(input string name, input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp_prod, input int exp_lat);
    logic [15:0] prod;
    int          lat;
    logic        bsy;
    logic        dn;
    do_op(s, av, bv, prod, lat, bsy, dn);
    n_cmp++; if (prod !== exp_prod) begin n_mis++; $display("FAIL %s product got %h want %h", name, prod, exp_prod); end
    n_cmp++; if (lat != exp_lat)    begin n_mis++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
    n_cmp++; if (bsy !== 1'b0)      begin n_mis++; $display("FAIL %s busy_in_done got %b want 0", name, bsy); end
    n_cmp++; if (dn !== 1'b0)       begin n_mis++; $display("FAIL %s done_width got %b want 0 one cycle later", name, dn); end
  endtask

  task automatic test_ignored_start();
    int lat;
    int extra_done;
    int busy_seen;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 8'd13; b = 8'd11;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);                       // INIT executes, now in CHECK
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; a = 8'd2; b = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 2;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    n_cmp++; if (product !== 16'h008F) begin n_mis++; $display("FAIL ign_check product got %h want 008f", product); end
    n_cmp++; if (lat != pick(21, 14))  begin n_mis++; $display("FAIL ign_check latency got %0d want %0d", lat, pick(21, 14)); end
    start = 1'b1; a = 8'd1; b = 8'd1;     // held across the DONE edge
    @(posedge clk);
    #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL ign_done busy got %b want 0", busy); end
    extra_done = 0; busy_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
      if (busy) busy_seen++;
    end
    n_cmp++; if (extra_done != 0) begin n_mis++; $display("FAIL ign_done extra_done got %0d want 0", extra_done); end
    n_cmp++; if (busy_seen != 0)  begin n_mis++; $display("FAIL ign_done busy_cycles got %0d want 0", busy_seen); end
    n_cmp++; if (product !== 16'h008F) begin n_mis++; $display("FAIL ign_done product_held got %h want 008f", product); end
  endtask

  task automatic test_reset_abort();
    int extra_done;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 8'd200; b = 8'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);            // bits 0,1 shift; bit 2 CHECK -> now in ADD
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL abort busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_mis++; $display("FAIL abort busy got %b want 0", busy); end
    n_cmp++; if (product !== 16'h0) begin n_mis++; $display("FAIL abort product got %h want 0000", product); end
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) extra_done++;
    end
    n_cmp++; if (extra_done != 0) begin n_mis++; $display("FAIL abort done_count got %0d want 0", extra_done); end
    n_cmp++; if (busy !== 1'b0)   begin n_mis++; $display("FAIL abort busy_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_vec("u_13x11",      1'b0, 8'd13,  8'd11,  16'h008F, pick(21, 14));
    test_vec("s_m3x5",       1'b1, 8'hFD,  8'h05,  16'hFFF1, pick(20, 11));
    test_vec("u_255x255",    1'b0, 8'hFF,  8'hFF,  16'hFE01, pick(26, 26));
    test_vec("s_m128xm128",  1'b1, 8'h80,  8'h80,  16'h4000, pick(19, 19));
    test_vec("s_m128x127",   1'b1, 8'h80,  8'h7F,  16'hC080, pick(25, 24));
    test_vec("s_0xm1",       1'b1, 8'h00,  8'hFF,  16'h0000, pick(19, 6));
    test_vec("s_5xm7",       1'b1, 8'h05,  8'hF9,  16'hFFDD, pick(21, 12));
    test_vec("u_7x0",        1'b0, 8'd7,   8'd0,   16'h0000, pick(18, 3));
    test_vec("u_9x1",        1'b0, 8'd9,   8'd1,   16'h0009, pick(19, 6));
    test_vec("u_m1x2_unsig", 1'b0, 8'hFF,  8'h02,  16'h01FE, pick(19, 8));
    test_ignored_start();
    test_reset_abort();
    test_vec("u_200x100",    1'b0, 8'd200, 8'd100, 16'h4E20, pick(21, 20));
    test_vec("b2b_s_m1xm1",  1'b1, 8'hFF,  8'hFF,  16'h0001, pick(19, 6));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
